// File: rtl/lsq_unit_pkg.sv
// Shared types, encodings and lane helpers for the load/store queue.
package lsq_unit_pkg;

  localparam int unsigned XLEN = 32;

  // funct3 encodings; the store forms SB/SH/SW share the LB/LH/LW values.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } lsq_state_e;

  typedef struct packed {
    logic            is_store;
    logic [2:0]      funct3;
    logic [4:0]      regd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addr;
  } lsq_entry_t;

  localparam int unsigned ENTRY_W = $bits(lsq_entry_t);

  // Access size comes from funct3[1:0]: 00 byte, 01 half, anything else word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsq_fifo.sv
// Circular entry store for the LSQ: extra-bit pointers, registered full, flush.
module lsq_fifo #(
  parameter int unsigned C_DEPTH = 4,
  parameter int unsigned C_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               resetb_i,
  input  logic               clk_en_i,
  input  logic               push_i,
  input  logic [C_WIDTH-1:0] push_data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [C_WIDTH-1:0] head_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int unsigned AW = $clog2(C_DEPTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_d;
  logic               full_q, full_d;
  logic               push_ok;
  logic [C_WIDTH-1:0] mem_q [C_DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = full_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update: writes while full are dropped, and a flush discards any same-cycle write.
  always_comb begin
    push_ok  = push_i & ~full_q & ~flush_i;
    wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    count_d = wr_ptr_d - rd_ptr_d;
    full_d  = (count_d == (AW+1)'(C_DEPTH));
  end

  // Pointer and full-flag registers, frozen while the clock enable is low.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
    end else if (clk_en_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
    end
  end

  // Entry storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk_i) begin
    if (clk_en_i && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/lsq_unit.sv
// In-order load/store queue: buffers EX memory ops, issues them one at a time,
// aligns store lanes, extends load data and reports misalign/access faults.
module lsq_unit
  import lsq_unit_pkg::*;
#(
  parameter int unsigned C_XLEN  = 32,
  parameter int unsigned C_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              clk_en_i,
  input  logic              resetb_i,
  output logic              ex_lq_full_o,
  input  logic              ex_lq_wr_i,
  input  logic              ex_sq_wr_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [4:0]        ex_regd_addr_i,
  input  logic [C_XLEN-1:0] ex_regs2_data_i,
  input  logic [C_XLEN-1:0] ex_addr_i,
  output logic              dreq_valid_o,
  input  logic              dreq_ready_i,
  output logic              dreq_wr_o,
  output logic [C_XLEN-1:0] dreq_addr_o,
  output logic [3:0]        dreq_be_o,
  output logic [C_XLEN-1:0] dreq_data_o,
  input  logic              drsp_valid_i,
  input  logic              drsp_error_i,
  input  logic [C_XLEN-1:0] drsp_data_i,
  output logic              regd_wr_o,
  output logic [4:0]        regd_addr_o,
  output logic [C_XLEN-1:0] regd_data_o,
  output logic              hvec_lmis_o,
  output logic              hvec_smis_o,
  output logic              hvec_laf_o,
  output logic              hvec_saf_o,
  output logic [C_XLEN-1:0] hvec_badaddr_o
);

  lsq_state_e  state_q, state_d;
  lsq_entry_t  push_entry, head;
  logic        fifo_empty, fifo_pop, fifo_flush, head_mis, req_active;
  logic [31:0] rsp_shifted, load_ext, store_lanes;

  logic        regd_wr_q, regd_wr_d;
  logic [4:0]  regd_addr_q, regd_addr_d;
  logic [31:0] regd_data_q, regd_data_d;
  logic        lmis_q, lmis_d, smis_q, smis_d, laf_q, laf_d, saf_q, saf_d;
  logic [31:0] badaddr_q, badaddr_d;

  assign push_entry = '{is_store: ex_sq_wr_i, funct3: ex_funct3_i, regd: ex_regd_addr_i,
                        data: ex_regs2_data_i, addr: ex_addr_i};

  lsq_fifo #(
    .C_DEPTH (C_DEPTH),
    .C_WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .resetb_i    (resetb_i),
    .clk_en_i    (clk_en_i),
    .push_i      (ex_lq_wr_i | ex_sq_wr_i),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (ex_lq_full_o)
  );

  // Load extraction: shift the addressed byte/half down, then sign or zero extend.
  always_comb begin
    rsp_shifted = drsp_data_i >> {head.addr[1:0], 3'b000};
    case (head.funct3)
      F3_LB:   load_ext = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      F3_LH:   load_ext = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      F3_LBU:  load_ext = {24'h0, rsp_shifted[7:0]};
      F3_LHU:  load_ext = {16'h0, rsp_shifted[15:0]};
      default: load_ext = drsp_data_i;
    endcase
  end

  // Store lanes: replicate the byte/half so the byte enables pick the right copy.
  always_comb begin
    case (head.funct3[1:0])
      2'b00:   store_lanes = {4{head.data[7:0]}};
      2'b01:   store_lanes = {2{head.data[15:0]}};
      default: store_lanes = head.data;
    endcase
  end

  // Head-entry sequencer: alignment check, bus request, response retirement.
  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    req_active  = 1'b0;
    regd_wr_d   = 1'b0;
    regd_addr_d = 5'd0;
    regd_data_d = 32'd0;
    lmis_d      = 1'b0;
    smis_d      = 1'b0;
    laf_d       = 1'b0;
    saf_d       = 1'b0;
    badaddr_d   = 32'd0;
    head_mis    = is_misaligned(head.funct3, head.addr[1:0]);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_mis) begin
            lmis_d     = ~head.is_store;
            smis_d     = head.is_store;
            badaddr_d  = head.addr;
            fifo_flush = 1'b1;
          end else begin
            // Issue straight from IDLE so a fresh entry reaches the bus next cycle.
            req_active = 1'b1;
            state_d    = dreq_ready_i ? ST_RSP : ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_active = 1'b1;
        if (dreq_ready_i) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (drsp_valid_i) begin
          state_d = ST_IDLE;
          if (drsp_error_i) begin
            laf_d      = ~head.is_store;
            saf_d      = head.is_store;
            badaddr_d  = head.addr;
            fifo_flush = 1'b1;
          end else begin
            fifo_pop = 1'b1;
            if (!head.is_store && head.regd != 5'd0) begin
              regd_wr_d   = 1'b1;
              regd_addr_d = head.regd;
              regd_data_d = load_ext;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A request is only visible when the clock enable lets the handshake register.
  assign dreq_valid_o = req_active & clk_en_i;
  assign dreq_wr_o    = dreq_valid_o & head.is_store;
  assign dreq_addr_o  = dreq_valid_o ? {head.addr[31:2], 2'b00} : '0;
  assign dreq_be_o    = dreq_valid_o ? lane_be(head.funct3, head.addr[1:0]) : 4'b0000;
  assign dreq_data_o  = (dreq_valid_o && head.is_store) ? store_lanes : '0;

  assign regd_wr_o      = regd_wr_q;
  assign regd_addr_o    = regd_addr_q;
  assign regd_data_o    = regd_data_q;
  assign hvec_lmis_o    = lmis_q;
  assign hvec_smis_o    = smis_q;
  assign hvec_laf_o     = laf_q;
  assign hvec_saf_o     = saf_q;
  assign hvec_badaddr_o = badaddr_q;

  // State and one-cycle writeback/exception pulses, held while the enable is low.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q     <= ST_IDLE;
      regd_wr_q   <= 1'b0;
      regd_addr_q <= 5'd0;
      regd_data_q <= 32'd0;
      lmis_q      <= 1'b0;
      smis_q      <= 1'b0;
      laf_q       <= 1'b0;
      saf_q       <= 1'b0;
      badaddr_q   <= 32'd0;
    end else if (clk_en_i) begin
      state_q     <= state_d;
      regd_wr_q   <= regd_wr_d;
      regd_addr_q <= regd_addr_d;
      regd_data_q <= regd_data_d;
      lmis_q      <= lmis_d;
      smis_q      <= smis_d;
      laf_q       <= laf_d;
      saf_q       <= saf_d;
      badaddr_q   <= badaddr_d;
    end
  end

  // EX has a single memory slot, so load and store strobes are mutually exclusive.
  assert property (@(posedge clk_i) disable iff (!resetb_i) !(ex_lq_wr_i && ex_sq_wr_i));

endmodule

// File: tb/tb_lsq_unit.sv
// Directed bench for lsq_unit: one task per scenario, inline comparisons.
module tb_lsq_unit;

  logic        clk_i = 1'b0;
  logic        clk_en_i, resetb_i;
  logic        ex_lq_full_o, ex_lq_wr_i, ex_sq_wr_i;
  logic [2:0]  ex_funct3_i;
  logic [4:0]  ex_regd_addr_i;
  logic [31:0] ex_regs2_data_i, ex_addr_i;
  logic        dreq_valid_o, dreq_ready_i, dreq_wr_o;
  logic [31:0] dreq_addr_o, dreq_data_o;
  logic [3:0]  dreq_be_o;
  logic        drsp_valid_i, drsp_error_i;
  logic [31:0] drsp_data_i;
  logic        regd_wr_o;
  logic [4:0]  regd_addr_o;
  logic [31:0] regd_data_o;
  logic        hvec_lmis_o, hvec_smis_o, hvec_laf_o, hvec_saf_o;
  logic [31:0] hvec_badaddr_o;

  always #5 clk_i = ~clk_i;

  lsq_unit #(.C_XLEN(32), .C_DEPTH(4)) dut (
    .clk_i(clk_i), .clk_en_i(clk_en_i), .resetb_i(resetb_i),
    .ex_lq_full_o(ex_lq_full_o), .ex_lq_wr_i(ex_lq_wr_i), .ex_sq_wr_i(ex_sq_wr_i),
    .ex_funct3_i(ex_funct3_i), .ex_regd_addr_i(ex_regd_addr_i),
    .ex_regs2_data_i(ex_regs2_data_i), .ex_addr_i(ex_addr_i),
    .dreq_valid_o(dreq_valid_o), .dreq_ready_i(dreq_ready_i), .dreq_wr_o(dreq_wr_o),
    .dreq_addr_o(dreq_addr_o), .dreq_be_o(dreq_be_o), .dreq_data_o(dreq_data_o),
    .drsp_valid_i(drsp_valid_i), .drsp_error_i(drsp_error_i), .drsp_data_i(drsp_data_i),
    .regd_wr_o(regd_wr_o), .regd_addr_o(regd_addr_o), .regd_data_o(regd_data_o),
    .hvec_lmis_o(hvec_lmis_o), .hvec_smis_o(hvec_smis_o),
    .hvec_laf_o(hvec_laf_o), .hvec_saf_o(hvec_saf_o), .hvec_badaddr_o(hvec_badaddr_o)
  );

  int tests_run  = 0;
  int tests_fail = 0;

  // Values captured by serve() for the calling scenario to compare.
  logic        cap_timeout, cap_wr, cap_regd_wr, cap_full;
  int          cap_lat;
  logic [31:0] cap_addr, cap_data, cap_regd_data, cap_bad;
  logic [3:0]  cap_be, cap_hvec;
  logic [4:0]  cap_regd_addr;

  // Present one op on the EX strobes for a single cycle; returns on the following negedge.
  task automatic enq(input logic st, input logic [2:0] f3, input logic [4:0] rd,
                     input logic [31:0] d, input logic [31:0] a);
    ex_lq_wr_i = ~st; ex_sq_wr_i = st; ex_funct3_i = f3;
    ex_regd_addr_i = rd; ex_regs2_data_i = d; ex_addr_i = a;
    @(negedge clk_i);
    ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0;
  endtask

  // Act as the bus: accept the next request, respond one cycle later, capture the pulses.
  task automatic serve(input logic [31:0] rsp, input logic err);
    cap_timeout = 1'b1; cap_lat = 0; dreq_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (dreq_valid_o) begin
        cap_timeout = 1'b0;
        break;
      end
      @(negedge clk_i);
      cap_lat++;
    end
    if (cap_timeout) begin
      dreq_ready_i = 1'b0;
      return;
    end
    cap_wr = dreq_wr_o; cap_addr = dreq_addr_o; cap_be = dreq_be_o; cap_data = dreq_data_o;
    @(negedge clk_i);
    dreq_ready_i = 1'b0;
    drsp_valid_i = 1'b1; drsp_error_i = err; drsp_data_i = rsp;
    @(negedge clk_i);
    drsp_valid_i = 1'b0; drsp_error_i = 1'b0; drsp_data_i = 32'd0;
    cap_regd_wr = regd_wr_o; cap_regd_addr = regd_addr_o; cap_regd_data = regd_data_o;
    cap_hvec = {hvec_lmis_o, hvec_smis_o, hvec_laf_o, hvec_saf_o};
    cap_bad = hvec_badaddr_o; cap_full = ex_lq_full_o;
    $display("[TB] txn wr=%b addr=%h be=%b data=%h rsp=%h err=%b -> regd_wr=%b rd=%0d rdata=%h hvec=%b",
             cap_wr, cap_addr, cap_be, cap_data, rsp, err, cap_regd_wr, cap_regd_addr,
             cap_regd_data, cap_hvec);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    tests_run++; if (dreq_valid_o !== 1'b0) begin tests_fail++; $display("FAIL reset_dreq_valid: got %b want 0", dreq_valid_o); end
    tests_run++; if (ex_lq_full_o !== 1'b0) begin tests_fail++; $display("FAIL reset_full: got %b want 0", ex_lq_full_o); end
    tests_run++; if ({regd_wr_o, regd_addr_o, regd_data_o} !== 38'd0) begin tests_fail++; $display("FAIL reset_regd: got %b/%0d/%h want 0", regd_wr_o, regd_addr_o, regd_data_o); end
    tests_run++; if ({hvec_lmis_o, hvec_smis_o, hvec_laf_o, hvec_saf_o, hvec_badaddr_o} !== 36'd0) begin tests_fail++; $display("FAIL reset_hvec: got %b%b%b%b/%h want 0", hvec_lmis_o, hvec_smis_o, hvec_laf_o, hvec_saf_o, hvec_badaddr_o); end
    resetb_i = 1'b1;
    @(negedge clk_i);
    tests_run++; if (dreq_valid_o !== 1'b0) begin tests_fail++; $display("FAIL idle_empty_dreq: got %b want 0", dreq_valid_o); end
  endtask

  task automatic test_store_word();
    enq(1'b1, 3'b010, 5'd0, 32'hDEADBEEF, 32'h100);
    serve(32'd0, 1'b0);
    tests_run++; if (cap_timeout !== 1'b0) begin tests_fail++; $display("FAIL sw_issue: got timeout %b want 0", cap_timeout); end
    tests_run++; if (cap_lat !== 0) begin tests_fail++; $display("FAIL sw_latency: got %0d want 0", cap_lat); end
    tests_run++; if ({cap_wr, cap_be, cap_addr} !== {1'b1, 4'b1111, 32'h100}) begin tests_fail++; $display("FAIL sw_req: got wr=%b be=%b addr=%h want 1/1111/00000100", cap_wr, cap_be, cap_addr); end
    tests_run++; if (cap_data !== 32'hDEADBEEF) begin tests_fail++; $display("FAIL sw_data: got %h want deadbeef", cap_data); end
    tests_run++; if ({cap_hvec, cap_regd_wr} !== 5'b0) begin tests_fail++; $display("FAIL sw_no_pulse: got hvec=%b regd_wr=%b want 0", cap_hvec, cap_regd_wr); end
  endtask

  task automatic test_lanes();
    enq(1'b0, 3'b000, 5'd5, 32'd0, 32'h103);
    serve(32'h80000000, 1'b0);
    tests_run++; if ({cap_wr, cap_be, cap_addr} !== {1'b0, 4'b1000, 32'h100}) begin tests_fail++; $display("FAIL lb_req: got wr=%b be=%b addr=%h want 0/1000/00000100", cap_wr, cap_be, cap_addr); end
    tests_run++; if ({cap_regd_wr, cap_regd_addr, cap_regd_data} !== {1'b1, 5'd5, 32'hFFFFFF80}) begin tests_fail++; $display("FAIL lb_wb: got %b/%0d/%h want 1/5/ffffff80", cap_regd_wr, cap_regd_addr, cap_regd_data); end
    enq(1'b0, 3'b100, 5'd5, 32'd0, 32'h103);
    serve(32'h80000000, 1'b0);
    tests_run++; if ({cap_regd_wr, cap_regd_data} !== {1'b1, 32'h00000080}) begin tests_fail++; $display("FAIL lbu_wb: got %b/%h want 1/00000080", cap_regd_wr, cap_regd_data); end
    enq(1'b0, 3'b001, 5'd6, 32'd0, 32'h102);
    serve(32'h80010000, 1'b0);
    tests_run++; if ({cap_be, cap_hvec, cap_regd_data} !== {4'b1100, 4'b0000, 32'hFFFF8001}) begin tests_fail++; $display("FAIL lh_wb: got be=%b hvec=%b data=%h want 1100/0000/ffff8001", cap_be, cap_hvec, cap_regd_data); end
    enq(1'b0, 3'b101, 5'd6, 32'd0, 32'h102);
    serve(32'hABCD0000, 1'b0);
    tests_run++; if (cap_regd_data !== 32'h0000ABCD) begin tests_fail++; $display("FAIL lhu_wb: got %h want 0000abcd", cap_regd_data); end
    enq(1'b1, 3'b000, 5'd0, 32'h12345678, 32'h101);
    serve(32'd0, 1'b0);
    tests_run++; if ({cap_wr, cap_be, cap_data} !== {1'b1, 4'b0010, 32'h78787878}) begin tests_fail++; $display("FAIL sb_req: got wr=%b be=%b data=%h want 1/0010/78787878", cap_wr, cap_be, cap_data); end
    enq(1'b1, 3'b001, 5'd0, 32'hCAFEBEEF, 32'h102);
    serve(32'd0, 1'b0);
    tests_run++; if ({cap_be, cap_data} !== {4'b1100, 32'hBEEFBEEF}) begin tests_fail++; $display("FAIL sh_req: got be=%b data=%h want 1100/beefbeef", cap_be, cap_data); end
  endtask

  task automatic test_misaligned();
    logic seen;
    enq(1'b0, 3'b001, 5'd2, 32'd0, 32'h103);
    tests_run++; if (dreq_valid_o !== 1'b0) begin tests_fail++; $display("FAIL lh_mis_no_req: got %b want 0", dreq_valid_o); end
    enq(1'b0, 3'b010, 5'd3, 32'd0, 32'h200);  // lands in the flush cycle, so it is discarded
    tests_run++; if ({hvec_lmis_o, hvec_smis_o, hvec_laf_o, hvec_saf_o} !== 4'b1000) begin tests_fail++; $display("FAIL lh_mis_pulse: got %b%b%b%b want 1000", hvec_lmis_o, hvec_smis_o, hvec_laf_o, hvec_saf_o); end
    tests_run++; if (hvec_badaddr_o !== 32'h103) begin tests_fail++; $display("FAIL lh_mis_badaddr: got %h want 00000103", hvec_badaddr_o); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      seen |= dreq_valid_o | hvec_lmis_o;
    end
    tests_run++; if (seen !== 1'b0) begin tests_fail++; $display("FAIL lh_mis_flushed: got activity %b want 0", seen); end
    enq(1'b1, 3'b010, 5'd0, 32'h1, 32'h101);
    @(negedge clk_i);
    tests_run++; if ({hvec_lmis_o, hvec_smis_o, hvec_laf_o, hvec_saf_o, hvec_badaddr_o} !== {4'b0100, 32'h101}) begin tests_fail++; $display("FAIL sw_mis: got %b%b%b%b/%h want 0100/00000101", hvec_lmis_o, hvec_smis_o, hvec_laf_o, hvec_saf_o, hvec_badaddr_o); end
    @(negedge clk_i);
  endtask

  task automatic test_full_back_to_back();
    logic seen;
    dreq_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq(1'b0, 3'b010, 5'(i + 1), 32'd0, 32'h200 + 32'(4 * i));
      if (i == 2) begin
        tests_run++; if (ex_lq_full_o !== 1'b0) begin tests_fail++; $display("FAIL full_at_3: got %b want 0", ex_lq_full_o); end
      end
    end
    tests_run++; if (ex_lq_full_o !== 1'b1) begin tests_fail++; $display("FAIL full_at_4: got %b want 1", ex_lq_full_o); end
    enq(1'b0, 3'b010, 5'd9, 32'd0, 32'h300);
    tests_run++; if (ex_lq_full_o !== 1'b1) begin tests_fail++; $display("FAIL full_hold: got %b want 1", ex_lq_full_o); end
    for (int i = 0; i < 4; i++) begin
      serve(32'h1000 + 32'(i), 1'b0);
      tests_run++; if ({cap_timeout, cap_addr} !== {1'b0, 32'h200 + 32'(4 * i)}) begin tests_fail++; $display("FAIL fifo_order_%0d: got to=%b addr=%h want 0/%h", i, cap_timeout, cap_addr, 32'h200 + 32'(4 * i)); end
      tests_run++; if ({cap_regd_wr, cap_regd_addr, cap_regd_data} !== {1'b1, 5'(i + 1), 32'h1000 + 32'(i)}) begin tests_fail++; $display("FAIL fifo_wb_%0d: got %b/%0d/%h want 1/%0d/%h", i, cap_regd_wr, cap_regd_addr, cap_regd_data, i + 1, 32'h1000 + 32'(i)); end
      if (i == 0) begin
        tests_run++; if (cap_full !== 1'b0) begin tests_fail++; $display("FAIL full_drop: got %b want 0", cap_full); end
      end else begin
        tests_run++; if (cap_lat !== 0) begin tests_fail++; $display("FAIL b2b_latency_%0d: got %0d want 0", i, cap_lat); end
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      seen |= dreq_valid_o;
    end
    tests_run++; if (seen !== 1'b0) begin tests_fail++; $display("FAIL fifth_dropped: got dreq %b want 0", seen); end
  endtask

  task automatic test_store_fault();
    logic seen;
    dreq_ready_i = 1'b0;
    enq(1'b1, 3'b010, 5'd0, 32'h11, 32'h400);
    enq(1'b0, 3'b010, 5'd7, 32'd0, 32'h404);
    serve(32'd0, 1'b1);
    tests_run++; if ({cap_timeout, cap_wr, cap_addr} !== {1'b0, 1'b1, 32'h400}) begin tests_fail++; $display("FAIL saf_req: got to=%b wr=%b addr=%h want 0/1/00000400", cap_timeout, cap_wr, cap_addr); end
    tests_run++; if ({cap_hvec, cap_bad, cap_regd_wr} !== {4'b0001, 32'h400, 1'b0}) begin tests_fail++; $display("FAIL saf_pulse: got hvec=%b bad=%h wr=%b want 0001/00000400/0", cap_hvec, cap_bad, cap_regd_wr); end
    dreq_ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      seen |= dreq_valid_o;
    end
    dreq_ready_i = 1'b0;
    tests_run++; if (seen !== 1'b0) begin tests_fail++; $display("FAIL saf_flush: got dreq %b want 0", seen); end
  endtask

  task automatic test_load_x0();
    enq(1'b0, 3'b010, 5'd0, 32'd0, 32'h500);
    serve(32'hCAFEF00D, 1'b0);
    tests_run++; if ({cap_timeout, cap_addr} !== {1'b0, 32'h500}) begin tests_fail++; $display("FAIL x0_issue: got to=%b addr=%h want 0/00000500", cap_timeout, cap_addr); end
    tests_run++; if (cap_regd_wr !== 1'b0) begin tests_fail++; $display("FAIL x0_no_wb: got %b want 0", cap_regd_wr); end
    enq(1'b0, 3'b010, 5'd3, 32'd0, 32'h504);
    serve(32'h12345678, 1'b0);
    tests_run++; if ({cap_addr, cap_regd_wr, cap_regd_data} !== {32'h504, 1'b1, 32'h12345678}) begin tests_fail++; $display("FAIL x0_retired: got addr=%h wr=%b data=%h want 00000504/1/12345678", cap_addr, cap_regd_wr, cap_regd_data); end
  endtask

  task automatic test_clk_en();
    enq(1'b0, 3'b010, 5'd1, 32'd0, 32'h602);
    @(negedge clk_i);
    tests_run++; if (hvec_lmis_o !== 1'b1) begin tests_fail++; $display("FAIL cen_pulse: got %b want 1", hvec_lmis_o); end
    clk_en_i = 1'b0;
    @(negedge clk_i);
    tests_run++; if (hvec_lmis_o !== 1'b1) begin tests_fail++; $display("FAIL cen_hold: got %b want 1", hvec_lmis_o); end
    clk_en_i = 1'b1;
    @(negedge clk_i);
    tests_run++; if (hvec_lmis_o !== 1'b0) begin tests_fail++; $display("FAIL cen_clear: got %b want 0", hvec_lmis_o); end
  endtask

  task automatic test_reset_mid_txn();
    dreq_ready_i = 1'b0;
    enq(1'b0, 3'b010, 5'd4, 32'd0, 32'h700);
    @(negedge clk_i);
    tests_run++; if (dreq_valid_o !== 1'b1) begin tests_fail++; $display("FAIL rst_pre_req: got %b want 1", dreq_valid_o); end
    resetb_i = 1'b0;
    #1;
    tests_run++; if (dreq_valid_o !== 1'b0) begin tests_fail++; $display("FAIL rst_async: got %b want 0", dreq_valid_o); end
    @(negedge clk_i);
    resetb_i = 1'b1;
    drsp_valid_i = 1'b1; drsp_data_i = 32'h55;
    @(negedge clk_i);
    drsp_valid_i = 1'b0; drsp_data_i = 32'd0;
    tests_run++; if ({regd_wr_o, dreq_valid_o, ex_lq_full_o} !== 3'b000) begin tests_fail++; $display("FAIL rst_stray_rsp: got wr=%b dreq=%b full=%b want 000", regd_wr_o, dreq_valid_o, ex_lq_full_o); end
  endtask

  initial begin
    clk_en_i = 1'b1; resetb_i = 1'b0;
    ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0; ex_funct3_i = 3'd0; ex_regd_addr_i = 5'd0;
    ex_regs2_data_i = 32'd0; ex_addr_i = 32'd0;
    dreq_ready_i = 1'b0; drsp_valid_i = 1'b0; drsp_error_i = 1'b0; drsp_data_i = 32'd0;
    test_reset();
    test_store_word();
    test_lanes();
    test_misaligned();
    test_full_back_to_back();
    test_store_fault();
    test_load_x0();
    test_clk_en();
    test_reset_mid_txn();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
